weight_stream_feeder: RTL and testbench

Parametrised weight feeder for the systolic array. It holds up to two full ROWS×COLS weight matrices in a ping-pong buffer and streams them column by column into the array's weight inputs, one column per cycle. It supports ascending or descending column order and an optional per-row diagonal skew. It sits between the weight memory/loader and the array's weight-load ports.

---
 rtl/weight_stream_feeder.sv | 163 ++++++++++++++++
 tb/tb_weight_stream_feeder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_stream_feeder.sv
// Ping-pong weight buffer that streams a ROWSxCOLS matrix column by column into the array.
// Optional per-row diagonal skew is enabled by defining WEIGHT_STREAM_SKEW_EN.
module weight_stream_feeder #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           load_valid,
  output logic                           load_ready,
  input  logic [DW*ROWS*COLS-1:0]        load_data,
  input  logic                           start,
  input  logic                           reverse,
  output logic                           busy,
  output logic                           out_valid,
  output logic [ROWS-1:0][DW-1:0]        weight_out,
  output logic                           done
);

  localparam int MW = DW*ROWS*COLS;
  localparam int CW = $clog2(COLS+ROWS)+1;
`ifdef WEIGHT_STREAM_SKEW_EN
  localparam int SKEW = 1;
  localparam int SPAN = COLS+ROWS-1;
`else
  localparam int SKEW = 0;
  localparam int SPAN = COLS;
`endif
  localparam logic [CW-1:0] LAST_BEAT = CW'(SPAN-1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  typedef logic [ROWS-1:0][DW-1:0] wvec_t;

  state_t        state_r, state_s;
  logic [MW-1:0] bank_r [2];
  logic          wr_ptr_r, rd_ptr_r;
  logic [1:0]    occ_r, occ_s;
  logic [CW-1:0] beat_r, beat_s;
  logic          rev_r, rev_s;
  logic          load_fire_s, release_s;
  logic          out_valid_s, done_s;
  wvec_t         weight_s;
  logic          load_ready_r, busy_r, out_valid_r, done_r;
  wvec_t         weight_r;

  // Row r shows beat (stream cycle - r*SKEW); outside its column window it is zero.
  function automatic wvec_t beat_weights(input logic [MW-1:0] mat,
                                         input logic [CW-1:0] beat,
                                         input logic          rev);
    wvec_t w;
    int    k;
    int    col;
    w = '0;
    for (int r = 0; r < ROWS; r++) begin
      k = int'(beat) - r*SKEW;
      if (k >= 0 && k < COLS) begin
        col  = rev ? (COLS-1-k) : k;
        w[r] = mat[(r*COLS+col)*DW +: DW];
      end else begin
        w[r] = '0;
      end
    end
    return w;
  endfunction

  assign load_fire_s = load_valid && load_ready_r;

  // FSM next state and next registered outputs.
  always_comb begin
    state_s     = state_r;
    beat_s      = beat_r;
    rev_s       = rev_r;
    release_s   = 1'b0;
    out_valid_s = 1'b0;
    done_s      = 1'b0;
    weight_s    = '0;
    case (state_r)
      ST_IDLE: begin
        if (start && (occ_r != 2'd0)) begin
          state_s = ST_STREAM;
          beat_s  = {CW{1'b0}};
          rev_s   = reverse;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        // The done cycle itself is spent in STREAM so a start seen there is ignored.
        if (done_r) begin
          state_s   = ST_IDLE;
          release_s = 1'b1;
          beat_s    = {CW{1'b0}};
        end else begin
          out_valid_s = 1'b1;
          done_s      = (beat_r == LAST_BEAT);
          beat_s      = beat_r + CW'(1);
          weight_s    = beat_weights(bank_r[rd_ptr_r], beat_r, rev_r);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Occupancy update; a simultaneous load and release cancel out.
  always_comb begin
    occ_s = occ_r;
    case ({load_fire_s, release_s})
      2'b10:   occ_s = occ_r + 2'd1;
      2'b01:   occ_s = occ_r - 2'd1;
      default: occ_s = occ_r;
    endcase
  end

  // Control state, pointers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      beat_r       <= {CW{1'b0}};
      rev_r        <= 1'b0;
      occ_r        <= 2'd0;
      wr_ptr_r     <= 1'b0;
      rd_ptr_r     <= 1'b0;
      load_ready_r <= 1'b1;
      busy_r       <= 1'b0;
      out_valid_r  <= 1'b0;
      done_r       <= 1'b0;
      weight_r     <= '0;
    end else begin
      state_r      <= state_s;
      beat_r       <= beat_s;
      rev_r        <= rev_s;
      occ_r        <= occ_s;
      wr_ptr_r     <= load_fire_s ? ~wr_ptr_r : wr_ptr_r;
      rd_ptr_r     <= release_s ? ~rd_ptr_r : rd_ptr_r;
      load_ready_r <= (occ_s != 2'd2);
      busy_r       <= out_valid_s;
      out_valid_r  <= out_valid_s;
      done_r       <= done_s;
      weight_r     <= weight_s;
    end
  end

  // Matrix storage; contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (load_fire_s) begin
      bank_r[wr_ptr_r] <= load_data;
    end
  end

  assign load_ready = load_ready_r;
  assign busy       = busy_r;
  assign out_valid  = out_valid_r;
  assign done       = done_r;
  assign weight_out = weight_r;

endmodule

// File: tb/tb_weight_stream_feeder.sv
// Randomized scoreboard bench for weight_stream_feeder (honours WEIGHT_STREAM_SKEW_EN).
module tb_weight_stream_feeder;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 8;
  localparam int MW   = DW*ROWS*COLS;
`ifdef WEIGHT_STREAM_SKEW_EN
  localparam int SKEW = 1;
`else
  localparam int SKEW = 0;
`endif

  typedef struct {
    logic [ROWS-1:0][DW-1:0] w;
    logic                    d;
  } beat_t;

  logic                    clk;
  logic                    reset_n;
  logic                    load_valid;
  logic                    load_ready;
  logic [MW-1:0]           load_data;
  logic                    start;
  logic                    reverse;
  logic                    busy;
  logic                    out_valid;
  logic [ROWS-1:0][DW-1:0] weight_out;
  logic                    done;

  int            n_checks = 0;
  int            n_fail   = 0;
  beat_t         exp_q[$];
  logic [MW-1:0] model_mats[$];
  int            model_occ  = 0;
  bit            model_busy = 1'b0;

  weight_stream_feeder #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .start      (start),
    .reverse    (reverse),
    .busy       (busy),
    .out_valid  (out_valid),
    .weight_out (weight_out),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [MW-1:0] directed_matrix();
    logic [MW-1:0] m;
    m = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m[(r*COLS+c)*DW +: DW] = DW'(16*r + c + 1);
    return m;
  endfunction

  function automatic logic [MW-1:0] random_matrix();
    logic [MW-1:0] m;
    for (int i = 0; i < ROWS*COLS; i++) m[i*DW +: DW] = DW'($urandom_range(0, 255));
    return m;
  endfunction

  // Expected beats: column order first, then each row delayed by r cycles when skewed.
  task automatic push_stream(input logic [MW-1:0] m, input logic rev);
    int    order[COLS];
    int    span;
    int    k;
    beat_t b;
    for (int i = 0; i < COLS; i++) order[i] = rev ? (COLS-1-i) : i;
    span = COLS + SKEW*(ROWS-1);
    for (int j = 0; j < span; j++) begin
      b.w = '0;
      for (int r = 0; r < ROWS; r++) begin
        k = j - SKEW*r;
        if (k >= 0 && k < COLS) b.w[r] = m[(r*COLS+order[k])*DW +: DW];
      end
      b.d = (j == span-1);
      exp_q.push_back(b);
    end
  endtask

  // Monitor: pops an expected beat for every valid output cycle.
  always @(negedge clk) begin : monitor
    beat_t b;
    if (reset_n) begin
      chk("busy_eq_valid", 64'(busy), 64'(out_valid));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got weight %h expected no beat at %0t", weight_out, $time);
        end else begin
          b = exp_q.pop_front();
          chk("weight_out", 64'(weight_out), 64'(b.w));
          chk("done", 64'(done), 64'(b.d));
        end
      end else begin
        chk("idle_weight_zero", 64'(weight_out), 64'd0);
        chk("idle_done_zero", 64'(done), 64'd0);
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_weight"}, 64'(weight_out), 64'd0);
    chk({tag, "_load_ready"}, 64'(load_ready), 64'd1);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs(tag);
    exp_q.delete();
    model_mats.delete();
    model_occ  = 0;
    model_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic do_load(input logic [MW-1:0] m);
    bit acc;
    acc        = (model_occ < 2);
    load_valid = 1'b1;
    load_data  = m;
    chk("load_ready", 64'(load_ready), 64'(acc));
    @(posedge clk);
    #1 load_valid = 1'b0;
    if (acc) begin
      model_mats.push_back(m);
      model_occ++;
    end
  endtask

  task automatic do_start(input logic rev);
    bit acc;
    acc     = !model_busy && (model_occ > 0);
    start   = 1'b1;
    reverse = rev;
    @(posedge clk);
    #1 start = 1'b0;
    if (acc) begin
      model_busy = 1'b1;
      push_stream(model_mats.pop_front(), rev);
      @(negedge clk);
      chk("start_latency_gap", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("start_latency_first", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input bit start_in_done);
    bit seen;
    seen = 1'b0;
    if (model_busy) begin
      for (int i = 0; i < 64 && !seen; i++) begin
        @(negedge clk);
        if (done === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_timeout: got no done expected done within 64 cycles at %0t", $time);
      end
      if (start_in_done) begin
        start   = 1'b1;
        reverse = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1 start = 1'b0;
      model_occ--;
      model_busy = 1'b0;
      chk("load_ready_after_release", 64'(load_ready), 64'(model_occ < 2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1);
  end

  initial begin
    logic [MW-1:0] mat_a;
    reset_n    = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    start      = 1'b0;
    reverse    = 1'b0;
    #12;
    chk_reset_outputs("por");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // start with nothing buffered is ignored
    do_start(1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("empty_start_busy", 64'(busy), 64'd0);
    end
    @(posedge clk);
    #1;

    // directed matrix, forward then reverse
    mat_a = directed_matrix();
    do_load(mat_a);
    do_start(1'b0);
    wait_done(1'b0);
    do_load(mat_a);
    do_start(1'b1);
    wait_done(1'b0);

    // full buffer: third load refused until the first bank is released
    do_load(random_matrix());
    do_load(random_matrix());
    chk("full_load_ready", 64'(load_ready), 64'd0);
    do_load(random_matrix());
    do_start(1'b0);
    do_start(1'b1);
    wait_done(1'b0);
    do_load(random_matrix());
    do_start(1'b1);
    wait_done(1'b1);
    do_start(1'b0);
    wait_done(1'b0);

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(1, 2)) do_load(random_matrix());
      do_start(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) do_load(random_matrix());
      wait_done(1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // reset mid-stream, then mid-idle with a matrix buffered
    do_load(random_matrix());
    do_start(1'b0);
    do_reset("rst_stream");
    do_load(random_matrix());
    @(posedge clk);
    #1;
    do_reset("rst_idle");
    do_start(1'b1);
    repeat (6) @(posedge clk);
    #1;

    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
